// File: rtl/keypad_pkg.sv
// Shared keypad constants: key codes, the {col,row} key map and entry-action decode.
package keypad_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Element index is {col, row}, matching the snapshot bit layout col*4 + row.
  localparam logic [15:0][3:0] KEY_MAP = {
    KEY_D, KEY_C,  KEY_B, KEY_A,      // col 3: rows 3..0
    KEY_HASH, 4'd9, 4'd6, 4'd3,       // col 2
    4'd0,  4'd8,   4'd5,  4'd2,       // col 1
    KEY_STAR, 4'd7, 4'd4, 4'd1        // col 0
  };

  typedef enum logic [1:0] {
    ACT_DIGIT,
    ACT_CLEAR,
    ACT_COMMIT,
    ACT_NONE
  } key_action_e;

  function automatic key_action_e key_action(input logic [3:0] code);
    if (code <= 4'd9)            key_action = ACT_DIGIT;
    else if (code == KEY_STAR)   key_action = ACT_CLEAR;
    else if (code == KEY_HASH)   key_action = ACT_COMMIT;
    else                         key_action = ACT_NONE;
  endfunction

  function automatic logic [3:0] key_index(input logic [15:0] s);
    key_index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (s[i]) key_index = 4'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Key event and BCD entry outputs of the keypad, as seen by the display side.
interface keypad_entry_if;
  import keypad_pkg::*;

  logic                   key_valid;
  logic [3:0]             key_code;
  logic [4*DIGIT_W-1:0]   digits;
  logic [4*DIGIT_W-1:0]   value_out;
  logic                   entry_done;

  modport master (
    output key_valid, key_code, digits, value_out, entry_done
  );

  modport slave (
    input  key_valid, key_code, digits, value_out, entry_done
  );
endinterface

// File: rtl/keypad_scan.sv
// Column scanner: drives one column low per slot, synchronises rows and assembles a
// full-keypad snapshot (1 = pressed) with a frame_end strobe once it is complete.
module keypad_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        frame_end,
  output logic [15:0] snapshot
);

  localparam int SLOT_W = $clog2(SCAN_DIV);

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col;
  logic [3:0]        row_p0;
  logic [3:0]        row_p1;
  logic              slot_last;

  assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign col_out   = ~(4'b0001 << col);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      col       <= '0;
      row_p0    <= '0;
      row_p1    <= '0;
      snapshot  <= '0;
      frame_end <= 1'b0;
    end else begin
      row_p0    <= row_in;
      row_p1    <= row_p0;
      // Registered so the strobe lines up with the column-3 sample landing in snapshot.
      frame_end <= slot_last && (col == 2'd3);
      if (slot_last) begin
        slot_cnt                    <= '0;
        col                         <= col + 2'd1;
        snapshot[{col, 2'b00} +: 4] <= ~row_p1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad to 4-digit BCD entry: frame debounce, single-key press detection,
// and a rolling digit register committed by '#'.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     row_in,
  output logic [3:0]     col_out,
  keypad_entry_if.master kp
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic             frame_end;
  logic [15:0]      snapshot;
  logic [15:0]      prev_snapshot;
  logic [15:0]      accepted_state;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;

  logic             vld_p0;
  logic [3:0]       idx_p0;

  logic             key_valid_p1;
  logic [3:0]       key_code_p1;
  logic [15:0]      digits_p1;
  logic [15:0]      value_p1;
  logic             done_p1;

  logic [3:0]       evt_code;
  key_action_e      evt_act;

  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .frame_end (frame_end),
    .snapshot  (snapshot)
  );

  always_comb begin
    cnt_next = CNT_W'(1);
    if (snapshot == prev_snapshot) begin
      cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
    end
    accept = frame_end && (cnt_next == CNT_MAX) && (snapshot != accepted_state);
  end

  // Stage p0: debounce and detect an idle-to-single-key transition of accepted_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snapshot  <= '0;
      accepted_state <= '0;
      stable_cnt     <= '0;
      vld_p0         <= 1'b0;
      idx_p0         <= '0;
    end else begin
      vld_p0 <= 1'b0;
      if (frame_end) begin
        stable_cnt    <= cnt_next;
        prev_snapshot <= snapshot;
      end
      if (accept) begin
        accepted_state <= snapshot;
        vld_p0         <= (accepted_state == '0) && $onehot(snapshot);
        idx_p0         <= key_index(snapshot);
      end
    end
  end

  assign evt_code = KEY_MAP[idx_p0];
  assign evt_act  = key_action(evt_code);

  // Stage p1: key event outputs and entry register update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_p1 <= 1'b0;
      key_code_p1  <= '0;
      digits_p1    <= '0;
      value_p1     <= '0;
      done_p1      <= 1'b0;
    end else begin
      key_valid_p1 <= vld_p0;
      done_p1      <= 1'b0;
      if (vld_p0) begin
        key_code_p1 <= evt_code;
        unique case (evt_act)
          ACT_DIGIT:  digits_p1 <= {digits_p1[11:0], evt_code};
          ACT_CLEAR:  digits_p1 <= '0;
          ACT_COMMIT: begin
            value_p1  <= digits_p1;
            done_p1   <= 1'b1;
            digits_p1 <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign kp.key_valid  = key_valid_p1;
  assign kp.key_code   = key_code_p1;
  assign kp.digits     = digits_p1;
  assign kp.value_out  = value_p1;
  assign kp.entry_done = done_p1;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: behavioural keypad matrix, entry model feeding a scoreboard
// of expected key events, and per-scenario tasks.
module tb_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  localparam logic [3:0] MAP [0:3][0:3] = '{
    '{4'd1,  4'd2, 4'd3,  4'd10},
    '{4'd4,  4'd5, 4'd6,  4'd11},
    '{4'd7,  4'd8, 4'd9,  4'd12},
    '{4'd14, 4'd0, 4'd15, 4'd13}
  };

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] digits;
    logic [15:0] value;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys = '0;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  int          done_pulses = 0;
  int          cyc = 0;
  int          last_pulse_cyc = 0;
  logic [15:0] m_digits = '0;
  logic [15:0] m_value  = '0;

  keypad_entry_if kif ();

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .kp      (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A pressed key shorts its row to whichever column is currently driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4 + r] && !col_out[c]) row_in[r] = 1'b0;
  end

  function automatic int kidx(input int r, input int c);
    return c * 4 + r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [3:0] code);
    exp_t e;
    e.code = code;
    e.done = 1'b0;
    if (code <= 4'd9) m_digits = {m_digits[11:0], code};
    else if (code == 4'd14) m_digits = '0;
    else if (code == 4'd15) begin
      m_value  = m_digits;
      m_digits = '0;
      e.done   = 1'b1;
    end
    e.digits = m_digits;
    e.value  = m_value;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && kif.entry_done && !kif.key_valid) begin
        errors++;
        $display("FAIL entry_done_alone got done=1 key_valid=0 want done only with key_valid");
      end
      if (!rst && kif.entry_done) done_pulses++;
      if (!rst && kif.key_valid) begin
        pulses++;
        last_pulse_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key_valid got code=%0d digits=%h want no event",
                   kif.key_code, kif.digits);
        end else begin
          e = sb.pop_front();
          if ({kif.key_code, kif.digits, kif.value_out, kif.entry_done} !== e) begin
            errors++;
            $display("FAIL key_event got code=%0d digits=%h value=%h done=%b want code=%0d digits=%h value=%h done=%b",
                     kif.key_code, kif.digits, kif.value_out, kif.entry_done,
                     e.code, e.digits, e.value, e.done);
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 10 * FRAME) begin
      tick(1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_events got pending=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic press(input int r, input int c, input bit expect_evt);
    if (expect_evt) push_expect(MAP[r][c]);
    keys = '0;
    keys[kidx(r, c)] = 1'b1;
    tick(4 * FRAME);
    keys = '0;
    tick(4 * FRAME);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    keys = '0;
    sb.delete();
    m_digits = '0;
    m_value  = '0;
    tick(3);
    checks += 6;
    if (col_out !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", col_out); end
    if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b want 0", kif.key_valid); end
    if (kif.key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code got %h want 0", kif.key_code); end
    if (kif.digits !== 16'h0) begin errors++; $display("FAIL reset_digits got %h want 0000", kif.digits); end
    if (kif.value_out !== 16'h0) begin errors++; $display("FAIL reset_value got %h want 0000", kif.value_out); end
    if (kif.entry_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", kif.entry_done); end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    int p0 = pulses;
    for (int i = 0; i < 8 * SCAN_DIV; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      checks++;
      if (col_out !== exp_col) begin
        errors++;
        $display("FAIL scan_col cycle=%0d got %b want %b", i, col_out, exp_col);
      end
    end
    tick(2 * FRAME);
    checks += 2;
    if (pulses != p0) begin errors++; $display("FAIL idle_pulses got %0d want 0", pulses - p0); end
    if (kif.digits !== 16'h0000) begin errors++; $display("FAIL idle_digits got %h want 0000", kif.digits); end
  endtask

  task automatic test_hold_five();
    int p0 = pulses;
    int start = cyc;
    push_expect(4'd5);
    keys = '0;
    keys[kidx(1, 1)] = 1'b1;
    tick(4 * FRAME);
    keys = '0;
    tick(4 * FRAME);
    wait_drain("hold5");
    checks += 4;
    if (pulses - p0 != 1) begin errors++; $display("FAIL hold5_pulses got %0d want 1", pulses - p0); end
    if (last_pulse_cyc - start > 3 * FRAME) begin
      errors++; $display("FAIL hold5_latency got %0d cycles want <= %0d", last_pulse_cyc - start, 3 * FRAME);
    end
    if (kif.key_code !== 4'd5) begin errors++; $display("FAIL hold5_code got %0d want 5", kif.key_code); end
    if (kif.digits !== 16'h0005) begin errors++; $display("FAIL hold5_digits got %h want 0005", kif.digits); end
  endtask

  task automatic test_roll();
    press(0, 0, 1'b1);
    press(0, 1, 1'b1);
    press(0, 2, 1'b1);
    press(1, 0, 1'b1);
    press(1, 1, 1'b1);
    wait_drain("roll");
    checks++;
    if (kif.digits !== 16'h2345) begin errors++; $display("FAIL roll_digits got %h want 2345", kif.digits); end
  endtask

  task automatic test_letter_star();
    press(0, 3, 1'b1);
    wait_drain("letter");
    checks += 2;
    if (kif.digits !== 16'h2345) begin errors++; $display("FAIL letter_digits got %h want 2345", kif.digits); end
    if (kif.key_code !== 4'd10) begin errors++; $display("FAIL letter_code got %0d want 10", kif.key_code); end
    press(3, 0, 1'b1);
    wait_drain("star");
    checks++;
    if (kif.digits !== 16'h0000) begin errors++; $display("FAIL star_digits got %h want 0000", kif.digits); end
  endtask

  task automatic test_commit();
    int d0 = done_pulses;
    press(2, 2, 1'b1);
    press(2, 1, 1'b1);
    press(3, 2, 1'b1);
    wait_drain("commit");
    checks += 4;
    if (done_pulses - d0 != 1) begin errors++; $display("FAIL commit_done_pulses got %0d want 1", done_pulses - d0); end
    if (kif.value_out !== 16'h0098) begin errors++; $display("FAIL commit_value got %h want 0098", kif.value_out); end
    if (kif.digits !== 16'h0000) begin errors++; $display("FAIL commit_digits got %h want 0000", kif.digits); end
    if (kif.key_code !== 4'd15) begin errors++; $display("FAIL commit_code got %0d want 15", kif.key_code); end
  endtask

  task automatic test_ghost();
    int p0 = pulses;
    keys = '0;
    keys[kidx(1, 0)] = 1'b1;
    keys[kidx(2, 0)] = 1'b1;
    tick(4 * FRAME);
    keys = '0;
    tick(4 * FRAME);
    checks++;
    if (pulses != p0) begin errors++; $display("FAIL ghost_pulses got %0d want 0", pulses - p0); end
    press(2, 0, 1'b1);
    wait_drain("ghost7");
    checks += 2;
    if (kif.key_code !== 4'd7) begin errors++; $display("FAIL ghost7_code got %0d want 7", kif.key_code); end
    if (kif.digits !== 16'h0007) begin errors++; $display("FAIL ghost7_digits got %h want 0007", kif.digits); end
  endtask

  task automatic test_bounce_reset();
    int p0 = pulses;
    push_expect(4'd1);
    keys = '0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      keys[kidx(0, 0)] = ((i / 3) % 2) == 0;
      tick(1);
    end
    keys[kidx(0, 0)] = 1'b1;
    tick(4 * FRAME);
    wait_drain("bounce");
    checks += 3;
    if (pulses - p0 != 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", pulses - p0); end
    if (kif.key_code !== 4'd1) begin errors++; $display("FAIL bounce_code got %0d want 1", kif.key_code); end
    if (kif.digits !== 16'h0071) begin errors++; $display("FAIL bounce_digits got %h want 0071", kif.digits); end
    keys = '0;
    tick(4 * FRAME);
    // Press '2' and reset before two stable frames can accept it.
    keys[kidx(0, 1)] = 1'b1;
    tick(FRAME / 2 + 2);
    rst  = 1'b1;
    keys = '0;
    sb.delete();
    m_digits = '0;
    m_value  = '0;
    tick(2);
    checks += 5;
    if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid got %b want 0", kif.key_valid); end
    if (kif.key_code !== 4'h0) begin errors++; $display("FAIL rst_key_code got %0d want 0", kif.key_code); end
    if (kif.digits !== 16'h0) begin errors++; $display("FAIL rst_digits got %h want 0000", kif.digits); end
    if (kif.value_out !== 16'h0) begin errors++; $display("FAIL rst_value got %h want 0000", kif.value_out); end
    if (kif.entry_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", kif.entry_done); end
    rst = 1'b0;
    p0 = pulses;
    tick(1);
    checks++;
    if (col_out !== 4'b1110) begin errors++; $display("FAIL rst_release_col got %b want 1110", col_out); end
    tick(3 * FRAME);
    checks++;
    if (pulses != p0) begin errors++; $display("FAIL rst_spurious_pulses got %0d want 0", pulses - p0); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_idle_scan();
    test_hold_five();
    test_roll();
    test_letter_star();
    test_commit();
    test_ghost();
    test_bounce_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL final_queue got %0d want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
